fv_bank_array: RTL and testbench
================================

FV_BANK_ARRAY -- requirements
Module: fv_bank_array

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4: number of independent FV banks.
REQ-002 SHALL have parameter FV_WIDTH, default 16: FV word width in bits.
REQ-003 SHALL have parameter DEPTH, default 64, power of two: words per bank; AW = clog2(DEPTH).
REQ-004 SHALL have parameter TAG_W, default 2: Edge PE tag width.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, NUM_BANKS: per-bank request valid.
REQ-008 SHALL have port req_ready, output, NUM_BANKS: per-bank request accept.
REQ-009 SHALL have port req_rd_wr, input, NUM_BANKS: per bank, 1 = read, 0 = write.
REQ-010 SHALL have port req_addr, input, NUM_BANKS*AW: per-bank word address.
REQ-011 SHALL have port req_data, input, NUM_BANKS*FV_WIDTH: per-bank write data.
REQ-012 SHALL have port req_tag, input, NUM_BANKS*TAG_W: per-bank PE tag.
REQ-013 SHALL have port req_sos, input, NUM_BANKS: per-bank start-of-stream marker, passed through.
REQ-014 SHALL have port req_eos, input, NUM_BANKS: per-bank end-of-stream marker, passed through.
REQ-015 SHALL have port rd_valid, output, NUM_BANKS: per-bank read response valid.
REQ-016 SHALL have port rd_data, output, NUM_BANKS*FV_WIDTH: per-bank read data.
REQ-017 SHALL have port rd_tag, output, NUM_BANKS*TAG_W: per-bank read PE tag.
REQ-018 SHALL have ports rd_sos and rd_eos, output, NUM_BANKS each: per-bank read stream markers.
REQ-019 SHALL have port stream_begin, input, 1: starts a stream-out on all banks.
REQ-020 SHALL have port stream_len, input, AW+1: number of words to stream, range 1..DEPTH.
REQ-021 SHALL have ports st_valid, st_sos and st_eos, output, NUM_BANKS each: per-bank stream-out valid and markers.
REQ-022 SHALL have ports st_data (NUM_BANKS*FV_WIDTH) and st_addr (NUM_BANKS*AW), outputs: per-bank stream data and source address.
REQ-023 SHALL have port available, output, 1: high when every bank is IDLE.

Function
REQ-024 Each bank SHALL hold a DEPTH x FV_WIDTH single-port memory with 1-cycle registered read latency.
REQ-025 Each bank FSM SHALL have states IDLE, STREAM and LAST.
REQ-026 In IDLE, req_ready SHALL be 1 and a request SHALL be accepted when req_valid && req_ready.
REQ-027 An accepted write SHALL update mem[addr] at that edge and SHALL produce no response.
REQ-028 An accepted read SHALL assert rd_valid exactly one cycle later, with data = mem[addr] and tag/sos/eos registered from the request.
REQ-029 A read issued the cycle after a write to the same address SHALL return the new data.
REQ-030 When stream_begin is high in a cycle where all banks are IDLE, every bank SHALL enter STREAM, load counter = 0 and latch stream_len; same-cycle requests SHALL NOT be accepted (req_ready combinationally 0).
REQ-031 stream_begin while any bank is not IDLE SHALL be ignored; stream_len = 0 SHALL be ignored.
REQ-032 In STREAM, a bank SHALL read address counter each cycle and increment it; at counter = len-1 it SHALL go to LAST.
REQ-033 st_valid SHALL follow each stream read by one cycle, with st_addr = the address read, st_sos on word 0 and st_eos on word len-1; sos and eos both high when len = 1.
REQ-034 LAST SHALL return to IDLE after the final st_valid; available SHALL rise in that same cycle.
REQ-035 req_ready SHALL be 0 in STREAM and LAST.
REQ-036 stream_len = DEPTH SHALL stream addresses 0..DEPTH-1 without wrapping.
REQ-037 Banks SHALL operate independently for requests; streams SHALL be lock-stepped across banks.

Reset
REQ-038 On assertion of reset: all FSMs to IDLE; counters 0; rd_valid, st_valid, all sos/eos, rd_data, st_data, rd_tag and st_addr 0; available 1.
REQ-039 Reset asserted mid-stream SHALL abort the stream immediately with no further st_valid; memory contents are undefined.

Configuration
REQ-040 With macro FV_STREAM_EN defined, stream mode per REQ-030..036 SHALL be present.
REQ-041 Without FV_STREAM_EN, stream_begin SHALL be ignored, st_* outputs SHALL be tied to 0, banks SHALL stay IDLE, and available SHALL be constant 1.

Structure
REQ-042 A shared package SHALL hold the bank FSM state enum and the request and response packet typedefs.
REQ-043 One sub-module, fv_bank (FSM + memory + counter), SHALL be instantiated NUM_BANKS times in a generate loop.

Verification
REQ-044 Write 0xABCD to bank1 addr 5, then read it with tag 2 -> rd_valid[1] one cycle later, data 0xABCD, tag 2; other banks silent.
REQ-045 Write addr 3 = 0x1111, read addr 3 the next cycle -> returns 0x1111.
REQ-046 Fill addr 0..3 with 0x10..0x13, stream_begin with len 4 -> st_valid for 4 cycles, data 0x10..0x13, sos on word 0, eos on word 3, available low for 5 cycles total.
REQ-047 Stream with len 1 -> one st_valid with sos = eos = 1; req_valid held during the stream -> not accepted until available = 1.
REQ-048 Assert reset at stream word 2 -> st_valid 0 immediately; after release, available = 1 and req_ready all ones.
REQ-049 Build without FV_STREAM_EN, pulse stream_begin -> st_valid stays 0 and available stays 1.

Source files
------------

// File: rtl/fv_bank_array_pkg.sv
// rtl/fv_bank_array_pkg.sv - shared bank FSM state and request/response packet types
package fv_bank_array_pkg;

  typedef enum logic [1:0] {
    BANK_IDLE   = 2'd0,
    BANK_STREAM = 2'd1,
    BANK_LAST   = 2'd2
  } bank_state_e;

  typedef struct packed {
    logic rd_wr;
    logic sos;
    logic eos;
  } req_pkt_t;

  typedef struct packed {
    logic valid;
    logic sos;
    logic eos;
  } rsp_pkt_t;

endpackage

// File: rtl/fv_bank_array_if.sv
// rtl/fv_bank_array_if.sv - per-bank request, read-response and stream-out signal bundle
interface fv_bank_array_if #(
  parameter int NUM_BANKS = 4,
  parameter int FV_WIDTH  = 16,
  parameter int DEPTH     = 64,
  parameter int TAG_W     = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_BANKS-1:0]          req_valid;
  logic [NUM_BANKS-1:0]          req_ready;
  logic [NUM_BANKS-1:0]          req_rd_wr;
  logic [NUM_BANKS*AW-1:0]       req_addr;
  logic [NUM_BANKS*FV_WIDTH-1:0] req_data;
  logic [NUM_BANKS*TAG_W-1:0]    req_tag;
  logic [NUM_BANKS-1:0]          req_sos;
  logic [NUM_BANKS-1:0]          req_eos;
  logic [NUM_BANKS-1:0]          rd_valid;
  logic [NUM_BANKS*FV_WIDTH-1:0] rd_data;
  logic [NUM_BANKS*TAG_W-1:0]    rd_tag;
  logic [NUM_BANKS-1:0]          rd_sos;
  logic [NUM_BANKS-1:0]          rd_eos;
  logic [NUM_BANKS-1:0]          st_valid;
  logic [NUM_BANKS-1:0]          st_sos;
  logic [NUM_BANKS-1:0]          st_eos;
  logic [NUM_BANKS*FV_WIDTH-1:0] st_data;
  logic [NUM_BANKS*AW-1:0]       st_addr;

  modport master (
    output req_valid, req_rd_wr, req_addr, req_data, req_tag, req_sos, req_eos,
    input  req_ready, rd_valid, rd_data, rd_tag, rd_sos, rd_eos,
    input  st_valid, st_sos, st_eos, st_data, st_addr
  );

  modport slave (
    input  req_valid, req_rd_wr, req_addr, req_data, req_tag, req_sos, req_eos,
    output req_ready, rd_valid, rd_data, rd_tag, rd_sos, rd_eos,
    output st_valid, st_sos, st_eos, st_data, st_addr
  );
endinterface

// File: rtl/fv_bank.sv
// rtl/fv_bank.sv - one FV bank: single-port memory, request port, stream-out FSM
// Stream-out logic is built only when FV_STREAM_EN is defined.
module fv_bank
  import fv_bank_array_pkg::*;
#(
  parameter int  FV_WIDTH = 16,
  parameter int  DEPTH    = 64,
  parameter int  TAG_W    = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rd_wr,
  input  logic [AW-1:0]       req_addr,
  input  logic [FV_WIDTH-1:0] req_data,
  input  logic [TAG_W-1:0]    req_tag,
  input  logic                req_sos,
  input  logic                req_eos,
  output logic                rd_valid,
  output logic [FV_WIDTH-1:0] rd_data,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_sos,
  output logic                rd_eos,
  input  logic                stream_start,
  input  logic [AW:0]         stream_len,
  output logic                st_valid,
  output logic                st_sos,
  output logic                st_eos,
  output logic [FV_WIDTH-1:0] st_data,
  output logic [AW-1:0]       st_addr,
  output logic                idle
);
  logic [FV_WIDTH-1:0] mem [DEPTH];
  bank_state_e         state;
  req_pkt_t            req;
  rsp_pkt_t            rd_q;
  logic                start, accept, rd_acc, stream_rd;
  logic [AW-1:0]       rd_addr;
  logic [FV_WIDTH-1:0] data_q;
  logic [TAG_W-1:0]    tag_q;

  assign req       = '{rd_wr: req_rd_wr, sos: req_sos, eos: req_eos};
  assign idle      = (state == BANK_IDLE);
  assign req_ready = idle && !start;
  assign accept    = req_valid && req_ready;
  assign rd_acc    = accept && req.rd_wr;

  always_ff @(posedge clk) begin
    if (accept && !req.rd_wr) mem[req_addr] <= req_data;
  end

  // One registered read port shared by request reads and stream reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      tag_q  <= '0;
      rd_q   <= '0;
    end else begin
      rd_q <= '{valid: rd_acc, sos: rd_acc && req.sos, eos: rd_acc && req.eos};
      if (rd_acc || stream_rd) data_q <= mem[rd_addr];
      if (rd_acc) tag_q <= req_tag;
    end
  end

  assign rd_valid = rd_q.valid;
  assign rd_sos   = rd_q.sos;
  assign rd_eos   = rd_q.eos;
  assign rd_tag   = tag_q;
  assign rd_data  = rd_q.valid ? data_q : '0;

`ifdef FV_STREAM_EN
  bank_state_e   state_nxt;
  logic [AW-1:0] cnt;
  logic [AW:0]   len_q;
  logic          last_word;
  rsp_pkt_t      st_q;
  logic [AW-1:0] st_addr_q;

  assign start     = stream_start;
  assign stream_rd = (state == BANK_STREAM);
  assign rd_addr   = stream_rd ? cnt : req_addr;
  assign last_word = ({1'b0, cnt} == (len_q - (AW+1)'(1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= BANK_IDLE;
      cnt       <= '0;
      len_q     <= '0;
      st_q      <= '0;
      st_addr_q <= '0;
    end else begin
      state <= state_nxt;
      st_q  <= '{valid: stream_rd, sos: stream_rd && (cnt == '0), eos: stream_rd && last_word};
      if (stream_rd) begin
        cnt       <= cnt + AW'(1);
        st_addr_q <= cnt;
      end else if (idle && start) begin
        cnt   <= '0;
        len_q <= stream_len;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BANK_IDLE:   if (start) state_nxt = BANK_STREAM;
      BANK_STREAM: if (last_word) state_nxt = BANK_LAST;
      BANK_LAST:   state_nxt = BANK_IDLE;
      default:     state_nxt = BANK_IDLE;
    endcase
  end

  assign st_valid = st_q.valid;
  assign st_sos   = st_q.sos;
  assign st_eos   = st_q.eos;
  assign st_data  = st_q.valid ? data_q : '0;
  assign st_addr  = st_addr_q;
`else
  logic unused_stream;

  assign state         = BANK_IDLE;
  assign start         = 1'b0;
  assign stream_rd     = 1'b0;
  assign rd_addr       = req_addr;
  assign st_valid      = 1'b0;
  assign st_sos        = 1'b0;
  assign st_eos        = 1'b0;
  assign st_data       = '0;
  assign st_addr       = '0;
  assign unused_stream = ^{stream_start, stream_len};
`endif
endmodule

// File: rtl/fv_bank_array.sv
// rtl/fv_bank_array.sv - NUM_BANKS independent FV banks with lock-stepped stream-out
// Stream mode is enabled by defining FV_STREAM_EN.
module fv_bank_array
  import fv_bank_array_pkg::*;
#(
  parameter int  NUM_BANKS = 4,
  parameter int  FV_WIDTH  = 16,
  parameter int  DEPTH     = 64,
  parameter int  TAG_W     = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  fv_bank_array_if.slave bus,
  input  logic          stream_begin,
  input  logic [AW:0]   stream_len,
  output logic          available
);
  logic [NUM_BANKS-1:0] idle;
  logic                 stream_start;

  assign available    = &idle;
  // A single start pulse feeds every bank so streams stay in lock-step.
  assign stream_start = stream_begin && available && (stream_len != '0);

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    fv_bank #(
      .FV_WIDTH (FV_WIDTH),
      .DEPTH    (DEPTH),
      .TAG_W    (TAG_W)
    ) u_bank (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (bus.req_valid[i]),
      .req_ready    (bus.req_ready[i]),
      .req_rd_wr    (bus.req_rd_wr[i]),
      .req_addr     (bus.req_addr[i*AW +: AW]),
      .req_data     (bus.req_data[i*FV_WIDTH +: FV_WIDTH]),
      .req_tag      (bus.req_tag[i*TAG_W +: TAG_W]),
      .req_sos      (bus.req_sos[i]),
      .req_eos      (bus.req_eos[i]),
      .rd_valid     (bus.rd_valid[i]),
      .rd_data      (bus.rd_data[i*FV_WIDTH +: FV_WIDTH]),
      .rd_tag       (bus.rd_tag[i*TAG_W +: TAG_W]),
      .rd_sos       (bus.rd_sos[i]),
      .rd_eos       (bus.rd_eos[i]),
      .stream_start (stream_start),
      .stream_len   (stream_len),
      .st_valid     (bus.st_valid[i]),
      .st_sos       (bus.st_sos[i]),
      .st_eos       (bus.st_eos[i]),
      .st_data      (bus.st_data[i*FV_WIDTH +: FV_WIDTH]),
      .st_addr      (bus.st_addr[i*AW +: AW]),
      .idle         (idle[i])
    );
  end
endmodule

// File: tb/tb_fv_bank_array.sv
// tb/tb_fv_bank_array.sv - scoreboard bench for fv_bank_array (stream tests when FV_STREAM_EN)
module tb_fv_bank_array;
  import fv_bank_array_pkg::*;

  localparam int NB = 4;
  localparam int FW = 16;
  localparam int DEPTH = 64;
  localparam int TW = 2;
  localparam int AW = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stream_begin = 1'b0;
  logic [AW:0] stream_len = '0;
  logic        available;

  fv_bank_array_if #(.NUM_BANKS(NB), .FV_WIDTH(FW), .DEPTH(DEPTH), .TAG_W(TW)) bus ();

  fv_bank_array #(.NUM_BANKS(NB), .FV_WIDTH(FW), .DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .stream_begin (stream_begin),
    .stream_len   (stream_len),
    .available    (available)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            bank;
    logic [FW-1:0] data;
    logic [TW-1:0] tag;
    logic          sos;
    logic          eos;
    int            due;
  } rd_exp_t;

  typedef struct {
    logic [NB*FW-1:0] data;
    logic [AW-1:0]    addr;
    logic             sos;
    logic             eos;
    int               due;
  } st_exp_t;

  rd_exp_t       rd_q[$];
  st_exp_t       st_q[$];
  logic [FW-1:0] model[NB][DEPTH];
  bit            written[NB][DEPTH];

  // Read-response scoreboard.
  always @(negedge clk) begin
    rd_exp_t e;
    if (reset) begin
      if (rd_q.size() > 0 && rd_q[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL rd_missing bank %0d due cyc %0d, now cyc %0d with no response",
                 rd_q[0].bank, rd_q[0].due, cyc);
        void'(rd_q.pop_front());
      end
      for (int b = 0; b < NB; b++) begin
        if (bus.rd_valid[b]) begin
          checks++;
          if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected bank %0d data %h, expected no response",
                     b, bus.rd_data[b*FW +: FW]);
          end else begin
            e = rd_q.pop_front();
            if (e.bank !== b || e.due !== cyc || bus.rd_data[b*FW +: FW] !== e.data ||
                bus.rd_tag[b*TW +: TW] !== e.tag || bus.rd_sos[b] !== e.sos ||
                bus.rd_eos[b] !== e.eos) begin
              errors++;
              $display("FAIL rd_resp got bank %0d cyc %0d data %h tag %0d sos %b eos %b, expected bank %0d cyc %0d data %h tag %0d sos %b eos %b",
                       b, cyc, bus.rd_data[b*FW +: FW], bus.rd_tag[b*TW +: TW], bus.rd_sos[b],
                       bus.rd_eos[b], e.bank, e.due, e.data, e.tag, e.sos, e.eos);
            end
          end
        end
      end
    end
  end

`ifdef FV_STREAM_EN
  // Stream-out scoreboard: all banks must present the same word index together.
  always @(negedge clk) begin
    st_exp_t          e;
    logic [NB*AW-1:0] ea;
    if (reset && bus.st_valid != '0) begin
      checks++;
      if (st_q.size() == 0) begin
        errors++;
        $display("FAIL st_unexpected st_valid %b addr %h, expected none", bus.st_valid, bus.st_addr);
      end else begin
        e = st_q.pop_front();
        ea = {NB{e.addr}};
        if (bus.st_valid !== '1 || e.due !== cyc || bus.st_data !== e.data || bus.st_addr !== ea ||
            bus.st_sos !== {NB{e.sos}} || bus.st_eos !== {NB{e.eos}}) begin
          errors++;
          $display("FAIL st_word got valid %b cyc %0d data %h addr %h sos %b eos %b, expected valid 1111 cyc %0d data %h addr %h sos %b eos %b",
                   bus.st_valid, cyc, bus.st_data, bus.st_addr, bus.st_sos, bus.st_eos,
                   e.due, e.data, ea, {NB{e.sos}}, {NB{e.eos}});
        end
      end
    end
  end

  task automatic push_stream(input int len);
    st_exp_t e;
    for (int w = 0; w < len; w++) begin
      for (int b = 0; b < NB; b++) e.data[b*FW +: FW] = model[b][w];
      e.addr = AW'(w);
      e.sos  = (w == 0);
      e.eos  = (w == len - 1);
      e.due  = cyc + 2 + w;
      st_q.push_back(e);
    end
  endtask
`endif

  task automatic set_req(input int b, input logic rd, input logic [AW-1:0] a,
                         input logic [FW-1:0] d, input logic [TW-1:0] t,
                         input logic s, input logic eo);
    bus.req_valid[b]          = 1'b1;
    bus.req_rd_wr[b]          = rd;
    bus.req_addr[b*AW +: AW]  = a;
    bus.req_data[b*FW +: FW]  = d;
    bus.req_tag[b*TW +: TW]   = t;
    bus.req_sos[b]            = s;
    bus.req_eos[b]            = eo;
  endtask

  // Expects every driven request to be accepted at the coming edge.
  task automatic commit();
    rd_exp_t       e;
    logic [AW-1:0] a;
    for (int b = 0; b < NB; b++) begin
      if (bus.req_valid[b]) begin
        checks++;
        if (bus.req_ready[b] !== 1'b1) begin
          errors++;
          $display("FAIL req_ready bank %0d got %b, expected 1", b, bus.req_ready[b]);
        end
        a = bus.req_addr[b*AW +: AW];
        if (bus.req_rd_wr[b]) begin
          e.bank = b;
          e.data = model[b][a];
          e.tag  = bus.req_tag[b*TW +: TW];
          e.sos  = bus.req_sos[b];
          e.eos  = bus.req_eos[b];
          e.due  = cyc + 1;
          rd_q.push_back(e);
        end else begin
          model[b][a]   = bus.req_data[b*FW +: FW];
          written[b][a] = 1'b1;
        end
      end
    end
    @(negedge clk);
    bus.req_valid = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'hF || bus.rd_valid !== '0 || bus.st_valid !== '0 || available !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl got ready %b rd_valid %b st_valid %b avail %b, expected 1111 0000 0000 1",
               bus.req_ready, bus.rd_valid, bus.st_valid, available);
    end
    checks++;
    if (bus.rd_data !== '0 || bus.rd_tag !== '0 || bus.st_data !== '0 || bus.st_addr !== '0 ||
        bus.rd_sos !== '0 || bus.rd_eos !== '0 || bus.st_sos !== '0 || bus.st_eos !== '0) begin
      errors++;
      $display("FAIL reset_data got rd_data %h rd_tag %h st_data %h st_addr %h, expected all 0",
               bus.rd_data, bus.rd_tag, bus.st_data, bus.st_addr);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    set_req(1, 1'b0, 6'd5, 16'hABCD, 2'd0, 1'b0, 1'b0);
    commit();
    set_req(1, 1'b1, 6'd5, 16'h0000, 2'd2, 1'b1, 1'b0);
    commit();
    checks++;
    if (bus.rd_valid !== 4'b0010 || bus.rd_data[FW +: FW] !== 16'hABCD || bus.rd_tag[TW +: TW] !== 2'd2) begin
      errors++;
      $display("FAIL write_read got rd_valid %b data %h tag %0d, expected 0010 abcd 2",
               bus.rd_valid, bus.rd_data[FW +: FW], bus.rd_tag[TW +: TW]);
    end
  endtask

  task automatic test_raw();
    set_req(0, 1'b0, 6'd3, 16'h1111, 2'd0, 1'b0, 1'b0);
    commit();
    set_req(0, 1'b1, 6'd3, 16'h0000, 2'd1, 1'b0, 1'b1);
    set_req(2, 1'b0, 6'd3, 16'h2222, 2'd0, 1'b0, 1'b0);
    commit();
    checks++;
    if (bus.rd_valid !== 4'b0001 || bus.rd_data[FW-1:0] !== 16'h1111) begin
      errors++;
      $display("FAIL raw got rd_valid %b data %h, expected 0001 1111", bus.rd_valid, bus.rd_data[FW-1:0]);
    end
  endtask

  task automatic test_random();
    int a;
    for (int w = 0; w < 8; w++) begin
      for (int b = 0; b < NB; b++) set_req(b, 1'b0, AW'(w), FW'($urandom), 2'd0, 1'b0, 1'b0);
      commit();
    end
    for (int i = 0; i < 30; i++) begin
      for (int b = 0; b < NB; b++) begin
        a = $urandom_range(0, 15);
        if ($urandom_range(0, 1) == 1 && written[b][a])
          set_req(b, 1'b1, AW'(a), 16'h0, TW'($urandom), 1'($urandom), 1'($urandom));
        else if ($urandom_range(0, 2) != 0)
          set_req(b, 1'b0, AW'(a), FW'($urandom), 2'd0, 1'b0, 1'b0);
      end
      commit();
    end
  endtask

`ifdef FV_STREAM_EN
  task automatic test_stream();
    int low_cnt;
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < NB; b++) set_req(b, 1'b0, AW'(w), FW'(16'h10 + w + b * 16'h100), 2'd0, 1'b0, 1'b0);
      commit();
    end
    stream_len   = 7'd4;
    stream_begin = 1'b1;
    set_req(2, 1'b1, 6'd1, 16'h0, 2'd3, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.req_ready !== 4'h0) begin
      errors++;
      $display("FAIL begin_ready got %b, expected 0000", bus.req_ready);
    end
    push_stream(4);
    @(negedge clk);
    stream_begin  = 1'b0;
    bus.req_valid = '0;
    low_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (!available) low_cnt++;
      @(negedge clk);
    end
    checks++;
    if (low_cnt !== 5) begin
      errors++;
      $display("FAIL stream_avail_low got %0d cycles, expected 5", low_cnt);
    end
  endtask

  task automatic test_stream_len1();
    int waited;
    stream_len   = 7'd1;
    stream_begin = 1'b1;
    set_req(0, 1'b1, 6'd2, 16'h0, 2'd1, 1'b1, 1'b1);
    push_stream(1);
    @(negedge clk);
    stream_begin = 1'b0;
    waited = 0;
    while (!bus.req_ready[0] && waited < 10) begin
      waited++;
      @(negedge clk);
    end
    checks++;
    if (waited !== 2 || available !== 1'b1) begin
      errors++;
      $display("FAIL len1_hold got wait %0d avail %b, expected 2 1", waited, available);
    end
    commit();
  endtask

  task automatic test_stream_reset();
    bit found;
    stream_len   = 7'd8;
    stream_begin = 1'b1;
    push_stream(8);
    @(negedge clk);
    stream_begin = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.st_valid[0] && bus.st_addr[AW-1:0] == 6'd2) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stream_word2 not seen, expected st_addr 2 within 20 cycles");
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.st_valid !== '0 || available !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort got st_valid %b avail %b, expected 0000 1", bus.st_valid, available);
    end
    st_q.delete();
    for (int b = 0; b < NB; b++) for (int a = 0; a < DEPTH; a++) written[b][a] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.st_valid !== '0 || available !== 1'b1 || bus.req_ready !== 4'hF) begin
        errors++;
        $display("FAIL post_reset got st_valid %b avail %b ready %b, expected 0000 1 1111",
                 bus.st_valid, available, bus.req_ready);
      end
    end
  endtask
`else
  task automatic test_no_stream();
    stream_len   = 7'd4;
    stream_begin = 1'b1;
    set_req(3, 1'b1, 6'd0, 16'h0, 2'd3, 1'b1, 1'b1);
    commit();
    stream_begin = 1'b0;
    repeat (8) begin
      checks++;
      if (bus.st_valid !== '0 || available !== 1'b1) begin
        errors++;
        $display("FAIL no_stream got st_valid %b avail %b, expected 0000 1", bus.st_valid, available);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    bus.req_valid = '0;
    bus.req_rd_wr = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_tag   = '0;
    bus.req_sos   = '0;
    bus.req_eos   = '0;
    test_reset();
    test_write_read();
    test_raw();
    test_random();
`ifdef FV_STREAM_EN
    test_stream();
    test_stream_len1();
    test_stream_reset();
`else
    test_no_stream();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (rd_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d read and %0d stream entries outstanding, expected 0 0",
               rd_q.size(), st_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
